// File: rtl/operand_serializer.sv
// operand_serializer: parallel operand pair to LSB/MSB-first bit-pair stream with framing strobes
module operand_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int HI = MSB_FIRST ? WIDTH - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sr_a, sr_b, sr_a_n, sr_b_n;
    logic [CW-1:0] cnt, cnt_n;
    logic a_n, b_n, bv_n, fb_n, lb_n, accept;
    assign in_ready = state == IDLE || (state == SHIFT && last_bit && !abort);
    assign busy = state == SHIFT;
    assign accept = in_valid && in_ready;
    always_comb begin
        state_n = state;
        sr_a_n = sr_a;
        sr_b_n = sr_b;
        cnt_n = cnt;
        a_n = a;
        b_n = b;
        bv_n = bit_valid;
        fb_n = first_bit;
        lb_n = last_bit;
        if (accept) begin
            state_n = SHIFT;
            a_n = in_a[HI];
            b_n = in_b[HI];
            sr_a_n = MSB_FIRST ? in_a << 1 : in_a >> 1;
            sr_b_n = MSB_FIRST ? in_b << 1 : in_b >> 1;
            cnt_n = CW'(1);
            bv_n = 1'b1;
            fb_n = 1'b1;
            lb_n = WIDTH == 1;
        end else if (state == SHIFT && (abort || last_bit)) begin
            state_n = IDLE;
            sr_a_n = '0;
            sr_b_n = '0;
            cnt_n = '0;
            a_n = 1'b0;
            b_n = 1'b0;
            bv_n = 1'b0;
            fb_n = 1'b0;
            lb_n = 1'b0;
        end else if (state == SHIFT) begin
            a_n = MSB_FIRST ? sr_a[WIDTH-1] : sr_a[0];
            b_n = MSB_FIRST ? sr_b[WIDTH-1] : sr_b[0];
            sr_a_n = MSB_FIRST ? sr_a << 1 : sr_a >> 1;
            sr_b_n = MSB_FIRST ? sr_b << 1 : sr_b >> 1;
            fb_n = 1'b0;
            lb_n = cnt == LAST;
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr_a <= '0;
            sr_b <= '0;
            cnt <= '0;
            a <= 1'b0;
            b <= 1'b0;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit <= 1'b0;
        end else begin
            state <= state_n;
            sr_a <= sr_a_n;
            sr_b <= sr_b_n;
            cnt <= cnt_n;
            a <= a_n;
            b <= b_n;
            bit_valid <= bv_n;
            first_bit <= fb_n;
            last_bit <= lb_n;
        end
    end
endmodule

// File: tb/tb_operand_serializer.sv
// tb_operand_serializer: directed checks of LSB-first, MSB-first and 1-bit serializers
module tb_operand_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;

    logic v0 = 1'b0, r0, a0, b0, bv0, fb0, lb0, bz0;
    logic [7:0] ia0 = '0, ib0 = '0;
    logic v1 = 1'b0, r1, a1, b1, bv1, fb1, lb1, bz1;
    logic [7:0] ia1 = '0, ib1 = '0;
    logic v2 = 1'b0, r2, a2, b2, bv2, fb2, lb2, bz2;
    logic [0:0] ia2 = '0, ib2 = '0;

    operand_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_a(ia0), .in_b(ib0),
        .abort(abort), .a(a0), .b(b0), .bit_valid(bv0), .first_bit(fb0), .last_bit(lb0), .busy(bz0));
    operand_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(ia1), .in_b(ib1),
        .abort(abort), .a(a1), .b(b1), .bit_valid(bv1), .first_bit(fb1), .last_bit(lb1), .busy(bz1));
    operand_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_a(ia2), .in_b(ib2),
        .abort(abort), .a(a2), .b(b2), .bit_valid(bv2), .first_bit(fb2), .last_bit(lb2), .busy(bz2));

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        #2;
        got = {a0, b0, bv0, fb0, lb0, bz0, a1 | b1 | bv1 | bz1};
        total++;
        if (got !== 7'b0) begin bad++; $display("FAIL reset_outputs got=%b want=%b", got, 7'b0); end
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({r0, r1, r2} !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b want=111", {r0, r1, r2}); end
    endtask

    task automatic test_single();
        logic [7:0] sa = 8'b10100101, sb = 8'b00111100;
        logic [6:0] got, exp;
        ia0 = 8'hA5; ib0 = 8'h3C; v0 = 1'b1;
        step();
        v0 = 1'b0; ia0 = 8'h00; ib0 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            got = {a0, b0, bv0, fb0, lb0, r0, bz0};
            exp = {sa[7-i], sb[7-i], 1'b1, i == 0, i == 7, i == 7, 1'b1};
            total++;
            if (got !== exp) begin bad++; $display("FAIL single[%0d] got=%b want=%b", i, got, exp); end
            step();
        end
        got = {a0, b0, bv0, fb0, lb0, r0, bz0};
        total++;
        if (got !== 7'b0000010) begin bad++; $display("FAIL single_idle got=%b want=0000010", got); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sa = 8'b10100101, sb = 8'b00111100;
        logic [6:0] got, exp;
        ia0 = 8'hA5; ib0 = 8'h3C; v0 = 1'b1;
        step();
        v0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            got = {a0, b0, bv0, fb0, lb0, r0, bz0};
            exp = i < 8 ? {sa[7-i], sb[7-i], 1'b1, i == 0, i == 7, i == 7, 1'b1}
                        : {1'b1, i == 8, 1'b1, i == 8, i == 15, i == 15, 1'b1};
            total++;
            if (got !== exp) begin bad++; $display("FAIL b2b[%0d] got=%b want=%b", i, got, exp); end
            if (i == 7) begin ia0 = 8'hFF; ib0 = 8'h01; v0 = 1'b1; end
            if (i == 8) v0 = 1'b0;
            step();
        end
        total++;
        if ({bv0, bz0} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b want=00", {bv0, bz0}); end
    endtask

    task automatic test_msb_first();
        logic [4:0] got, exp;
        ia1 = 8'h80; ib1 = 8'h01; v1 = 1'b1;
        step();
        v1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got = {a1, b1, bv1, fb1, lb1};
            exp = {i == 0, i == 7, 1'b1, i == 0, i == 7};
            total++;
            if (got !== exp) begin bad++; $display("FAIL msb[%0d] got=%b want=%b", i, got, exp); end
            step();
        end
        total++;
        if ({a1, b1, bv1, bz1} !== 4'b0) begin bad++; $display("FAIL msb_idle got=%b want=0000", {a1, b1, bv1, bz1}); end
    endtask

    task automatic test_abort();
        ia0 = 8'hA5; ib0 = 8'h3C; v0 = 1'b1;
        step();
        v0 = 1'b0;
        repeat (3) step();
        abort = 1'b1;
        #1;
        total++;
        if (r0 !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", r0); end
        step();
        total++;
        if ({a0, bv0, bz0, r0} !== 4'b0001) begin bad++; $display("FAIL abort_flush got=%b want=0001", {a0, bv0, bz0, r0}); end
        abort = 1'b0;
        ia0 = 8'h01; ib0 = 8'h00; v0 = 1'b1;
        step();
        v0 = 1'b0;
        total++;
        if ({a0, b0, bv0, fb0, lb0} !== 5'b10110) begin bad++; $display("FAIL abort_next got=%b want=10110", {a0, b0, bv0, fb0, lb0}); end
        repeat (7) step();
        total++;
        if ({lb0, r0} !== 2'b11) begin bad++; $display("FAIL abort_last_pre got=%b want=11", {lb0, r0}); end
        abort = 1'b1; ia0 = 8'hFF; ib0 = 8'hFF; v0 = 1'b1;
        #1;
        total++;
        if (r0 !== 1'b0) begin bad++; $display("FAIL abort_wins_ready got=%b want=0", r0); end
        step();
        abort = 1'b0; v0 = 1'b0;
        total++;
        if ({a0, bv0, bz0} !== 3'b000) begin bad++; $display("FAIL abort_wins got=%b want=000", {a0, bv0, bz0}); end
        step();
        total++;
        if ({bv0, bz0} !== 2'b00) begin bad++; $display("FAIL abort_no_accept got=%b want=00", {bv0, bz0}); end
    endtask

    task automatic test_rst_mid();
        ia0 = 8'hFF; ib0 = 8'hFF; v0 = 1'b1;
        step();
        v0 = 1'b0;
        repeat (2) step();
        #1 rst = 1'b1;
        #1;
        total++;
        if ({a0, b0, bv0, bz0, fb0, lb0} !== 6'b0) begin bad++; $display("FAIL rst_async got=%b want=000000", {a0, b0, bv0, bz0, fb0, lb0}); end
        #1 rst = 1'b0;
        #1;
        total++;
        if (r0 !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", r0); end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if ({a0, b0, bv0, bz0} !== 4'b0) begin bad++; $display("FAIL rst_no_resume[%0d] got=%b want=0000", i, {a0, b0, bv0, bz0}); end
        end
    endtask

    task automatic test_width1();
        logic [2:0] sa = 3'b101, sb = 3'b010;
        ia2 = sa[2]; ib2 = sb[2]; v2 = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({a2, b2, bv2, fb2, lb2, r2} !== {sa[2-i], sb[2-i], 4'b1111}) begin
                bad++;
                $display("FAIL w1[%0d] got=%b want=%b", i, {a2, b2, bv2, fb2, lb2, r2}, {sa[2-i], sb[2-i], 4'b1111});
            end
            if (i < 2) begin ia2 = sa[1-i]; ib2 = sb[1-i]; end else v2 = 1'b0;
            step();
        end
        total++;
        if ({a2, bv2, bz2} !== 3'b000) begin bad++; $display("FAIL w1_idle got=%b want=000", {a2, bv2, bz2}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_msb_first();
        test_abort();
        test_rst_mid();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
